// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the sequential multiplier: FSM state encoding,
// the residue width, and the mod-3 step and multiply helpers.
package mult_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int RES_W = 2;

   // Folding in one more bit MSB-first: new residue = (2*r + bit) mod 3.
   function automatic logic [RES_W-1:0] mod3_step(input logic [RES_W-1:0] r,
                                                  input logic bit_in);
      logic [2:0] v;
      logic [RES_W-1:0] res;
      v = {r, bit_in};
      case (v)
         3'd0, 3'd3: res = 2'd0;
         3'd1, 3'd4: res = 2'd1;
         3'd2, 3'd5: res = 2'd2;
         default:    res = 2'd0;
      endcase
      return res;
   endfunction

   function automatic logic [RES_W-1:0] mod3_mul(input logic [RES_W-1:0] ra,
                                                 input logic [RES_W-1:0] rb);
      logic [3:0] p;
      logic [RES_W-1:0] res;
      p = {2'b00, ra} * {2'b00, rb};
      case (p)
         4'd0, 4'd3, 4'd6, 4'd9: res = 2'd0;
         4'd1, 4'd4, 4'd7:       res = 2'd1;
         4'd2, 4'd5, 4'd8:       res = 2'd2;
         default:                res = 2'd0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mult_seq_mod3_residue.sv
// Combinational mod-3 residue of an unsigned word of parametrised width,
// folded MSB-first one bit at a time.
module mod3_residue
   import mult_seq_pkg::*;
#(
   parameter int WIDTH_IN = 4
) (
   input  logic [WIDTH_IN-1:0] i_x,
   output logic [RES_W-1:0]    o_res
);

   logic [RES_W-1:0] w_res;

   always_comb begin
      w_res = '0;
      for (int i = WIDTH_IN - 1; i >= 0; i--) begin
         w_res = mod3_step(w_res, i_x[i]);
      end
      o_res = w_res;
   end

endmodule

// File: rtl/mult_seq_resilient.sv
// Radix-2 shift-add sequential multiplier with valid/ready handshakes and an
// optional mod-3 residue check on the product (enabled by RESIDUE_CHECK_EN).
//
//  state | meaning
//  IDLE  | waiting for an operand pair, in_ready=1
//  BUSY  | one shift-add step per cycle, WIDTH steps
//  DONE  | product held with out_valid=1 until out_ready
module mult_seq_resilient
   import mult_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               fault
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   state_t r_state;
   state_t w_state_nxt;

   logic [2*WIDTH:0]   r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [CW-1:0]      r_cnt;
   logic               w_accept;
   logic               w_step;

   assign w_accept = (r_state == IDLE) && in_valid;
   assign w_step   = (r_state == BUSY);

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_nxt = BUSY;
         BUSY:    if (r_cnt == LAST_STEP) w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Multiplicand shifts left while the multiplier is consumed LSB-first.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else if (w_accept) begin
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, a};
         r_mplier <= b;
         r_cnt    <= '0;
      end else if (w_step) begin
         if (r_mplier[0]) r_acc <= r_acc + {1'b0, r_mcand};
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CW'(1);
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign product   = r_acc[2*WIDTH-1:0];

`ifdef RESIDUE_CHECK_EN
   logic [RES_W-1:0] w_ra;
   logic [RES_W-1:0] w_rb;
   logic [RES_W-1:0] w_rp;
   logic [RES_W-1:0] r_ra;
   logic [RES_W-1:0] r_rb;

   mod3_residue #(.WIDTH_IN(WIDTH)) u_res_a (.i_x(a), .o_res(w_ra));
   mod3_residue #(.WIDTH_IN(WIDTH)) u_res_b (.i_x(b), .o_res(w_rb));
   mod3_residue #(.WIDTH_IN(2*WIDTH)) u_res_p (.i_x(product), .o_res(w_rp));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ra <= '0;
         r_rb <= '0;
      end else if (w_accept) begin
         r_ra <= w_ra;
         r_rb <= w_rb;
      end
   end

   assign fault = out_valid && (w_rp != mod3_mul(r_ra, r_rb));
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_mult_seq_resilient.sv
// Directed, table-driven bench for mult_seq_resilient at WIDTH=4 plus one
// WIDTH=8 instance for the all-ones case.
module tb_mult_seq_resilient;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready, fault;
   logic [3:0] a, b;
   logic [7:0] product;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, fault8;
   logic [7:0]  a8, b8;
   logic [15:0] product8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mult_seq_resilient #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .product(product), .fault(fault)
   );

   mult_seq_resilient #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
      .product(product8), .fault(fault8)
   );

   typedef struct {
      logic [3:0] va;
      logic [3:0] vb;
      int         hold;
      logic [7:0] exp_p;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [3:0] xa, input logic [3:0] xb, input int hold,
                         input bit keep_valid, input logic [7:0] exp_p, input string tag);
      int cyc;
      @(negedge clk);
      check({tag, " in_ready idle"}, in_ready, 1);
      a = xa; b = xb; in_valid = 1'b1;
      @(posedge clk); #1;
      if (!keep_valid) in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      check({tag, " latency"}, cyc, 4);
      check({tag, " product"}, product, exp_p);
      check({tag, " fault"}, fault, 0);
      check({tag, " in_ready done"}, in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, " held product"}, product, exp_p);
         check({tag, " held out_valid"}, out_valid, 1);
         check({tag, " held in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " release out_valid"}, out_valid, 0);
      check({tag, " release in_ready"}, in_ready, 1);
   endtask

   initial begin
      int cyc;
      int seen;
      logic exp_flip_fault;

      vecs[0] = '{4'd15, 4'd15, 0, 8'hE1};
      vecs[1] = '{4'd6,  4'd7,  5, 8'd42};
      vecs[2] = '{4'd3,  4'd5,  0, 8'd15};
      vecs[3] = '{4'd1,  4'd1,  1, 8'd1};
      vecs[4] = '{4'd9,  4'd0,  0, 8'd0};
      vecs[5] = '{4'd8,  4'd8,  2, 8'd64};
      vecs[6] = '{4'd15, 4'd1,  0, 8'd15};
      vecs[7] = '{4'd12, 4'd10, 0, 8'd120};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset product", product, 0);
      check("reset fault", fault, 0);
      check("reset counter", dut.r_cnt, 0);
      check("reset8 product", product8, 0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         run_op(vecs[i].va, vecs[i].vb, vecs[i].hold, 1'b0, vecs[i].exp_p, $sformatf("vec%0d", i));

      run_op(4'd0, 4'd9, 0, 1'b1, 8'd0, "zero_hold_valid");

      // Abort mid-operation with reset after step 2.
      @(negedge clk);
      a = 4'd13; b = 4'd11; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort in_ready", in_ready, 1);
      check("abort out_valid", out_valid, 0);
      check("abort product", product, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("abort no out_valid", seen, 0);
      run_op(4'd3, 4'd5, 0, 1'b0, 8'd15, "after_abort");

      // Reset wins over in_valid in the same cycle.
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; a = 4'd7; b = 4'd7;
      @(posedge clk); #1;
      check("rst priority in_ready", in_ready, 1);
      rst = 1'b0; in_valid = 1'b0;

      // Corrupt accumulator bit 0 after step 1 of 5*3: 5 -> 4, final 14.
`ifdef RESIDUE_CHECK_EN
      exp_flip_fault = 1'b1;
`else
      exp_flip_fault = 1'b0;
`endif
      @(negedge clk);
      a = 4'd5; b = 4'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      dut.r_acc = dut.r_acc ^ 9'd1;
      cyc = 1;
      while (!out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("flip latency", cyc, 4);
      check("flip product", product, 14);
      check("flip fault", fault, {31'd0, exp_flip_fault});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("flip release", in_ready, 1);

      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            run_op(4'(i), 4'(j), 0, 1'b0, 8'(i * j), $sformatf("sweep %0d*%0d", i, j));

      @(negedge clk);
      a8 = 8'd255; b8 = 8'd255; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      cyc = 0;
      while (!out_valid8 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("w8 latency", cyc, 8);
      check("w8 product", product8, 65025);
      check("w8 fault", fault8, 0);
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      check("w8 release", in_ready8, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_seq_resilient.md
MULT_SEQ_RESILIENT -- requirements
Module: mult_seq_resilient

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits (unsigned), legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand pair valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  multiplicand, unsigned.
REQ-007 SHALL have port b  input  WIDTH  multiplier, unsigned.
REQ-008 SHALL have port out_valid  output  1  product valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts product.
REQ-010 SHALL have port product  output  2*WIDTH  a*b, unsigned, no truncation.
REQ-011 SHALL have port fault  output  1  residue-check mismatch on the current product; qualified by out_valid.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 IDLE with in_valid=1 SHALL, on that edge, latch a and b, clear the accumulator and step counter, and enter BUSY.
REQ-015 BUSY SHALL perform one radix-2 shift-add step per cycle (LSB-first on b), WIDTH steps total.
REQ-016 The edge completing step WIDTH SHALL enter DONE; out_valid SHALL rise exactly WIDTH cycles after the accepting edge.
REQ-017 In DONE, product and fault SHALL stay stable until out_ready=1; that edge SHALL return to IDLE.
REQ-018 in_valid in BUSY or DONE SHALL be ignored; operands are not queued.
REQ-019 The accumulator SHALL be 2*WIDTH+1 bits internally; product SHALL equal a*b exactly for all inputs, including all-ones operands.
REQ-020 Zero operands SHALL still take WIDTH cycles (no early termination).
REQ-021 The step counter SHALL be $clog2(WIDTH+1) bits and SHALL NOT wrap within an operation.

Reset
REQ-022 rst=1 SHALL force IDLE on the next edge, regardless of state, aborting any operation in flight.
REQ-023 After reset: in_ready=1, out_valid=0, product=0, fault=0, counter=0.
REQ-024 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-025 Macro RESIDUE_CHECK_EN SHALL control the fault-detection feature.
REQ-026 With RESIDUE_CHECK_EN defined, the block SHALL compute ra=a mod 3 and rb=b mod 3 at accept, and in DONE set fault=1 iff (product mod 3) != (ra*rb mod 3).
REQ-027 Without RESIDUE_CHECK_EN, fault SHALL be constant 0 and no residue logic SHALL be synthesised; cycle timing SHALL be identical.

Structure
REQ-028 Package mult_seq_pkg SHALL hold the FSM state typedef (IDLE/BUSY/DONE) and the residue width constant (2).
REQ-029 Mod-3 residue computation SHALL be a sub-module, mod3_residue, parametrised by input width; it is instantiated three times (a, b, product) when enabled.
REQ-030 The datapath SHALL contain no combinational path from a/b to product or fault.

Verification
REQ-031 WIDTH=4: a=15, b=15, accepted at edge 0 -> out_valid at edge 4, product=0x00E1, fault=0.
REQ-032 WIDTH=4: a=0, b=9 -> product=0 after 4 cycles; in_valid held high during BUSY does not start a second operation.
REQ-033 WIDTH=4: a=6, b=7, out_ready=0 for 5 cycles in DONE -> product=42 held stable, in_ready=0 throughout; IDLE on the edge with out_ready=1.
REQ-034 WIDTH=4: rst pulsed at BUSY step 2 -> IDLE next edge, out_valid never asserts; a following op a=3, b=5 -> product=15.
REQ-035 WIDTH=8: a=255, b=255 -> product=65025 at 8 cycles; exhaustive WIDTH=4 sweep matches a*b.
REQ-036 RESIDUE_CHECK_EN, WIDTH=4: a=5, b=3, accumulator bit 0 forced to flip during BUSY -> fault=1 with out_valid; same run without the macro -> fault=0.
